// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM:
// opcodes, state codes, datapath select codes and the decoded output bundle.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Codes 13..15 are unused; they decode to all-zero outputs.
    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       busy;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_control_if;

    logic [5:0] Op;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       Busy;

    modport master (
        input  Op, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Busy
    );

    modport slave (
        output Op, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Busy
    );

endinterface

// File: rtl/multicycle_control_outdec.sv
// Combinational Moore output decode: state (plus MemReady in fetch only) to the
// full control bundle. Unlisted signals default to 0 in every state.
module multicycle_control_outdec
    import multicycle_control_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o      = '0;
        ctrl_o.busy = (state_i >= S_DECODE) && (state_i <= S_ADDIWB);
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADDI;
            end
            S_ADDIWB: ctrl_o.reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register and
// opcode-driven sequencing; output decode lives in multicycle_control_outdec.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    logic [3:0] state_q, state_d;
    logic       mem_rdy;
    ctrl_t      ctrl;

    assign mem_rdy = MEM_WAIT_EN ? bus.MemReady : 1'b1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    multicycle_control_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_rdy),
        .ctrl_o      (ctrl)
    );

    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.Busy        = ctrl.busy;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model queues the
// expected control vector per cycle, and a negedge process checks every cycle.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef enum int {
        P_IDLE, P_FETCH, P_DECODE, P_ADDR, P_MEMRD, P_LWWB, P_MEMWR,
        P_EXEC, P_RWB, P_BEQ, P_J, P_ADDIEX, P_ADDIWB
    } ph_e;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [16:0] expq[$];

    multicycle_control_if bus ();

    multicycle_control u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] sw_state;
    logic       sw_rdy;
    ctrl_t      sw_ctrl;

    multicycle_control_outdec u_dec (
        .state_i     (sw_state),
        .mem_ready_i (sw_rdy),
        .ctrl_o      (sw_ctrl)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,
    //  ALUSrcB,ALUOp,PCSource,Busy}
    logic [16:0] dut_vec;
    assign dut_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                      bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                      bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Busy};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] phase_out(input ph_e p, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, busy;
        logic [1:0] srcb, aluop, pcsrc;
        pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0;
        m2r = 1'b0; rdst = 1'b0; rw = 1'b0; srca = 1'b0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        busy = (p != P_IDLE) && (p != P_FETCH);
        case (p)
            P_FETCH:  begin mr = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            P_DECODE: srcb = 2'b11;
            P_ADDR:   begin srca = 1'b1; srcb = 2'b10; end
            P_MEMRD:  begin mr = 1'b1; iord = 1'b1; end
            P_LWWB:   begin rw = 1'b1; m2r = 1'b1; end
            P_MEMWR:  begin mw = 1'b1; iord = 1'b1; end
            P_EXEC:   begin srca = 1'b1; aluop = 2'b10; end
            P_RWB:    begin rw = 1'b1; rdst = 1'b1; end
            P_BEQ:    begin srca = 1'b1; aluop = 2'b01; pcwc = 1'b1; pcsrc = 2'b01; end
            P_J:      begin pcw = 1'b1; pcsrc = 2'b10; end
            P_ADDIEX: begin srca = 1'b1; srcb = 2'b10; aluop = 2'b11; end
            P_ADDIWB: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, busy};
    endfunction

    always @(negedge clk) begin : compare
        logic [16:0] e;
        cyc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk($sformatf("cycle%0d", cyc), 32'(dut_vec), 32'(e));
        end
    end

    task automatic step(input logic rdy, input logic [5:0] op, input logic [16:0] exp,
                        input bit lit_en, input logic [16:0] lit, input string name);
        bus.MemReady = rdy;
        bus.Op = op;
        expq.push_back(exp);
        if (lit_en) begin
            #2;
            chk(name, 32'(dut_vec), 32'(lit));
            chk({name, "_model"}, 32'(exp), 32'(lit));
        end
        @(posedge clk);
        #1;
    endtask

    // Assumes inputs for the current cycle are already driven; ends back in fetch.
    task automatic async_reset(input logic [16:0] pre, input string name);
        #2;
        chk({name, "_pre"}, 32'(dut_vec), 32'(pre));
        reset = 1'b1;
        #1;
        chk({name, "_zero"}, 32'(dut_vec), 32'd0);
        @(posedge clk);
        #1;
        step(1'b1, 6'd0, phase_out(P_IDLE, 1'b1), 1'b0, 17'd0, "");
        reset = 1'b0;
        step(1'b1, 6'd0, phase_out(P_IDLE, 1'b1), 1'b0, 17'd0, "");
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int exp_len,
                             input int lit_idx, input logic [16:0] lit, input string name);
        ph_e plist[$];
        int n;
        logic r;
        logic [5:0] o;
        bit mem;
        case (op)
            OP_LW:    plist = '{P_DECODE, P_ADDR, P_MEMRD, P_LWWB};
            OP_SW:    plist = '{P_DECODE, P_ADDR, P_MEMWR};
            OP_RTYPE: plist = '{P_DECODE, P_EXEC, P_RWB};
            OP_ADDI:  plist = '{P_DECODE, P_ADDIEX, P_ADDIWB};
            OP_BEQ:   plist = '{P_DECODE, P_BEQ};
            OP_J:     plist = '{P_DECODE, P_J};
            default:  plist = '{P_DECODE};
        endcase
        n = 0;
        // Op is random outside decode/address so a stray sample would show up.
        for (int i = 0; i < fw; i++) begin
            step(1'b0, 6'($urandom), phase_out(P_FETCH, 1'b0), 1'b0, 17'd0, "");
            n++;
        end
        step(1'b1, 6'($urandom), phase_out(P_FETCH, 1'b1), 1'b0, 17'd0, "");
        n++;
        foreach (plist[k]) begin
            o = (plist[k] == P_DECODE || plist[k] == P_ADDR) ? op : 6'($urandom);
            mem = (plist[k] == P_MEMRD) || (plist[k] == P_MEMWR);
            if (mem) begin
                for (int w = 0; w < mw; w++) begin
                    step(1'b0, o, phase_out(plist[k], 1'b0), 1'b0, 17'd0, "");
                    n++;
                end
            end
            r = mem ? 1'b1 : 1'($urandom_range(0, 1));
            step(r, o, phase_out(plist[k], r), k == lit_idx, lit, name);
            n++;
        end
        chk({name, "_len"}, 32'(n), 32'(exp_len));
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : stim
        ph_e p;
        reset = 1'b1;
        bus.Op = 6'd0;
        bus.MemReady = 1'b1;
        sw_state = 4'd0;
        sw_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_vec), 32'd0);
        step(1'b1, 6'd0, phase_out(P_IDLE, 1'b1), 1'b0, 17'd0, "");
        reset = 1'b0;
        step(1'b1, 6'd0, phase_out(P_IDLE, 1'b1), 1'b0, 17'd0, "");

        // Now in fetch: assert reset between edges, outputs must drop at once.
        bus.MemReady = 1'b1;
        bus.Op = 6'($urandom);
        async_reset(17'b1001010000_01_00_00_0, "rst_fetch");

        run_instr(OP_LW,    0, 0, 5, 3, 17'b0000001010_00_00_00_1, "lw");
        run_instr(OP_RTYPE, 0, 0, 4, 2, 17'b0000000110_00_00_00_1, "rtype");
        run_instr(OP_ADDI,  0, 0, 4, 2, 17'b0000000010_00_00_00_1, "addi");
        run_instr(OP_SW,    0, 3, 7, 2, 17'b0010100000_00_00_00_1, "sw_wait");
        run_instr(OP_BEQ,   0, 0, 3, 1, 17'b0100000001_00_01_01_1, "beq");
        run_instr(OP_J,     0, 0, 3, 1, 17'b1000000000_00_00_10_1, "j");
        run_instr(6'b111111, 0, 0, 2, 0, 17'b0000000000_11_00_00_1, "illegal");
        run_instr(OP_LW,    2, 2, 9, 2, 17'b0011000000_00_00_00_1, "lw_wait");

        // lw interrupted by reset while stalled in the memory read.
        step(1'b1, 6'($urandom), phase_out(P_FETCH, 1'b1), 1'b0, 17'd0, "");
        step(1'b0, OP_LW, phase_out(P_DECODE, 1'b0), 1'b0, 17'd0, "");
        step(1'b0, OP_LW, phase_out(P_ADDR, 1'b0), 1'b0, 17'd0, "");
        bus.MemReady = 1'b0;
        bus.Op = 6'($urandom);
        async_reset(17'b0011000000_00_00_00_1, "rst_memrd");
        run_instr(OP_BEQ, 1, 0, 4, 1, 17'b0100000001_00_01_01_1, "beq_after_rst");

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);

        // Exhaustive output-decode sweep, including the unused codes.
        for (int s = 0; s < 16; s++) begin
            for (int rb = 0; rb < 2; rb++) begin
                sw_state = 4'(s);
                sw_rdy = 1'(rb);
                case (4'(s))
                    S_FETCH:  p = P_FETCH;
                    S_DECODE: p = P_DECODE;
                    S_MEMADR: p = P_ADDR;
                    S_MEMRD:  p = P_MEMRD;
                    S_MEMWB:  p = P_LWWB;
                    S_MEMWR:  p = P_MEMWR;
                    S_EXEC:   p = P_EXEC;
                    S_ALUWB:  p = P_RWB;
                    S_BRANCH: p = P_BEQ;
                    S_JUMP:   p = P_J;
                    S_ADDIEX: p = P_ADDIEX;
                    S_ADDIWB: p = P_ADDIWB;
                    default:  p = P_IDLE;
                endcase
                #1;
                chk($sformatf("outdec_s%0d_r%0d", s, rb), 32'(sw_ctrl),
                    32'(phase_out(p, 1'(rb))));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. Decodes the instruction opcode and sequences each instruction through fetch, decode, execute, memory and write-back cycles. Drives every datapath select and enable, including MemtoReg for the ALUOut/MDR write-back mux. Stretches memory cycles with a MemReady handshake.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states hold until MemReady=1; 0 = MemReady ignored (treated as 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state to S_RESET
Op  input  6  IR[31:26] opcode
MemReady  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU Zero
IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR
MemtoReg  output  1  write-back select: 0 = ALUOut, 1 = MDR
RegDst  output  1  0 = rt, 1 = rd
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct, 11 = add (addi)
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
Busy  output  1  high in every state except S_FETCH (instruction boundary)

Behaviour:
- Async active-high reset: state = S_RESET. In S_RESET all outputs are 0, including Busy. The first clk edge after reset deasserts moves the FSM to S_FETCH.
- Outputs are decoded from state only. MemReady gates only IRWrite/PCWrite in S_FETCH and the state advance. Every output not listed for a state is 0.
- S_FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stay while MemReady=0; go to S_DECODE when MemReady=1.
- S_DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 100011 (lw) and 101011 (sw) -> S_MEMADR
  - 000000 (R-type) -> S_EXEC
  - 000100 (beq) -> S_BRANCH
  - 000010 (j) -> S_JUMP
  - 001000 (addi) -> S_ADDIEX
  - any other Op -> S_FETCH (treated as NOP; no register or memory write)
- S_MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: MemRead=1, IorD=1. Hold until MemReady, then S_MEMWB.
- S_MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next S_FETCH.
- S_MEMWR: MemWrite=1, IorD=1. Hold until MemReady, then S_FETCH. MemWrite stays high throughout the hold.
- S_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next S_ALUWB.
- S_ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. Next S_FETCH.
- S_BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next S_FETCH.
- S_JUMP: PCWrite=1, PCSource=10. Next S_FETCH.
- S_ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next S_ADDIWB.
- S_ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0. Next S_FETCH.
- Cycle counts with MemReady=1 every cycle, including fetch:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - Each cycle MemReady=0 in a memory state adds 1.
- Op is sampled only in S_DECODE and S_MEMADR. Changes to Op in any other state have no effect.
- Reset asserted mid-instruction: the FSM goes to S_RESET immediately, without waiting for a clock. All enables drop the same cycle, and no partial write is completed.
- MEM_WAIT_EN=0: memory states always advance after one cycle, and IRWrite/PCWrite in S_FETCH are constant 1.
- State encoding: 4-bit binary. The 3 unused codes decode to all-zero outputs and return to S_FETCH on the next edge.

Decomposition:
- Shared package: opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI; the state enum/localparams; ALUOp, ALUSrcB and PCSource code constants.
- One natural sub-module, multicycle_control_outdec: purely combinational decode from state and MemReady to the output bundle. It is verified by exhaustive state sweep.
- The FSM register and next-state logic stay in the top module.

Test Plan:
- Reset: assert reset asynchronously between edges -> all outputs 0 at once. Release -> S_FETCH after 1 edge, with MemRead=1, IRWrite=1, PCWrite=1 (MemReady=1).
- lw (Op=100011), MemReady=1 -> 5 cycles. Only the 5th cycle has RegWrite=1, MemtoReg=1, RegDst=0. Then back in S_FETCH.
- R-type (Op=000000) then addi (Op=001000) -> 4 cycles each. Write-back cycles have MemtoReg=0, with RegDst=1 and RegDst=0 respectively.
- sw (Op=101011) with MemReady low for 3 cycles in S_MEMWR -> MemWrite held 4 cycles, IorD=1, RegWrite never 1. Total 7 cycles.
- beq (Op=000100) and j (Op=000010) -> 3 cycles each. PCWriteCond=1/PCSource=01 and PCWrite=1/PCSource=10 respectively.
- Illegal Op=111111 -> returns to S_FETCH after S_DECODE with no RegWrite/MemWrite. Reset asserted in S_MEMRD -> MemRead drops immediately.
